// File: rtl/prog_sequencer_if.sv
// ---------------------------------------------------------------------------
// prog_sequencer_if
// Bundles the Start/Halt handshake with the PC-register control outputs of
// the program run sequencer.
//   master : drives start/halt, observes the sequencer outputs
//   slave  : the sequencer itself
// Signals:
//   start        level, high = hold and arm, falling = begin execution
//   halt         decoded halt instruction at the current PC
//   pc_hold      1 = freeze the PC register
//   pc_load      1 = PC register loads pc_load_addr on the next edge
//   pc_load_addr entry address of the selected program
//   prog_idx     index of the current/armed program
//   running      1 while a program executes
//   done         1 after a halt or watchdog expiry, until the next start
//   cycle_count  executed cycles of the current/last program
//   timeout      watchdog expiry flag
// ---------------------------------------------------------------------------
interface prog_sequencer_if #(
  parameter int PC_W  = 11,
  parameter int CNT_W = 16
);
  logic             start;
  logic             halt;
  logic             pc_hold;
  logic             pc_load;
  logic [PC_W-1:0]  pc_load_addr;
  logic [1:0]       prog_idx;
  logic             running;
  logic             done;
  logic [CNT_W-1:0] cycle_count;
  logic             timeout;

  modport master (
    output start, halt,
    input  pc_hold, pc_load, pc_load_addr, prog_idx,
    input  running, done, cycle_count, timeout
  );

  modport slave (
    input  start, halt,
    output pc_hold, pc_load, pc_load_addr, prog_idx,
    output running, done, cycle_count, timeout
  );
endinterface

// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
// Run controller for the instruction-fetch program counter. Holds the PC
// while start is high, loads the selected program's entry address, releases
// the PC to run, stops on the decoded halt instruction and reports done
// together with the number of executed cycles. Successive start requests
// from the done state step through NUM_PROGS programs.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    prog_sequencer_if.slave (start/halt in, PC controls and status out)
// Optional feature:
//   PROG_WATCHDOG_EN  when defined, a run reaching WDOG_LIMIT cycles without
//                     halt ends in done with timeout set. When undefined no
//                     comparator exists and timeout is tied low.
// All outputs are registered except pc_load_addr.
// ---------------------------------------------------------------------------
module prog_sequencer #(
  parameter int PC_W       = 11,
  parameter int NUM_PROGS  = 3,
  parameter int PROG0_ADDR = 0,
  parameter int PROG1_ADDR = 256,
  parameter int PROG2_ADDR = 512,
  parameter int PROG3_ADDR = 768,
  parameter int CNT_W      = 16,
  parameter int WDOG_LIMIT = 4095
) (
  input logic                clk,
  input logic                rst_n,
  prog_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  localparam logic [1:0] LAST_IDX = 2'(NUM_PROGS - 1);

  state_t           state;
  logic [1:0]       prog_idx;
  logic [CNT_W-1:0] cycle_count;
  logic             pc_hold;
  logic             pc_load;
  logic             running;
  logic             done;
  logic [PC_W-1:0]  entry_addr;

`ifdef PROG_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDOG_CNT = CNT_W'(WDOG_LIMIT);
  logic timeout;
`endif

  // Indices at or beyond NUM_PROGS fall back to program 0.
  always_comb begin
    entry_addr = PC_W'(PROG0_ADDR);
    case (prog_idx)
      2'd1: if (NUM_PROGS > 1) entry_addr = PC_W'(PROG1_ADDR);
      2'd2: if (NUM_PROGS > 2) entry_addr = PC_W'(PROG2_ADDR);
      2'd3: if (NUM_PROGS > 3) entry_addr = PC_W'(PROG3_ADDR);
      default: entry_addr = PC_W'(PROG0_ADDR);
    endcase
  end

  // Single state machine; every output is set on the edge that enters the
  // state it belongs to, so the outputs track the state register exactly.
  // In RUN, start takes priority over halt so an abort always restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prog_idx    <= 2'd0;
      cycle_count <= '0;
      pc_hold     <= 1'b1;
      pc_load     <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
`ifdef PROG_WATCHDOG_EN
      timeout     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= ARMED;
            pc_hold <= 1'b1;
            pc_load <= 1'b1;
          end
        end
        ARMED: begin
          if (!bus.start) begin
            state       <= RUN;
            pc_hold     <= 1'b0;
            pc_load     <= 1'b0;
            running     <= 1'b1;
            cycle_count <= '0;
          end
        end
        RUN: begin
          if (bus.start) begin
            state   <= ARMED;
            pc_hold <= 1'b1;
            pc_load <= 1'b1;
            running <= 1'b0;
          end else if (bus.halt) begin
            state   <= DONE;
            pc_hold <= 1'b1;
            running <= 1'b0;
            done    <= 1'b1;
          end
`ifdef PROG_WATCHDOG_EN
          else if (cycle_count == WDOG_CNT) begin
            state   <= DONE;
            pc_hold <= 1'b1;
            running <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end
`endif
          else if (cycle_count != '1) begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.start) begin
            state    <= ARMED;
            pc_load  <= 1'b1;
            done     <= 1'b0;
            prog_idx <= (prog_idx >= LAST_IDX) ? 2'd0 : prog_idx + 2'd1;
`ifdef PROG_WATCHDOG_EN
            timeout  <= 1'b0;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          pc_hold <= 1'b1;
          pc_load <= 1'b0;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_hold      = pc_hold;
  assign bus.pc_load      = pc_load;
  assign bus.pc_load_addr = entry_addr;
  assign bus.prog_idx     = prog_idx;
  assign bus.running      = running;
  assign bus.done         = done;
  assign bus.cycle_count  = cycle_count;
`ifdef PROG_WATCHDOG_EN
  assign bus.timeout      = timeout;
`else
  assign bus.timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// ---------------------------------------------------------------------------
// tb_prog_sequencer
// Self-checking bench for prog_sequencer. Inputs change on the falling edge,
// outputs are compared on the following falling edge against a reference
// model that tracks the run phase, the length of the current run and the
// number of completed-program advances. A narrow counter (CNT_W = 6) lets
// long runs reach saturation. Build with PROG_WATCHDOG_EN to cover the
// watchdog; WDOG_LIMIT is 20 here.
// ---------------------------------------------------------------------------
module tb_prog_sequencer;

  localparam int PC_W       = 11;
  localparam int CNT_W      = 6;
  localparam int NUM_PROGS  = 3;
  localparam int WDOG_LIMIT = 20;
  localparam int MAX_COUNT  = (1 << CNT_W) - 1;
`ifdef PROG_WATCHDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  typedef enum {M_IDLE, M_ARMED, M_RUN, M_DONE} phase_t;

  logic clk = 1'b0;
  logic rst_n;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state
  phase_t phase;
  int     runLen;
  int     advances;
  bit     tmo;

  always #5 clk = ~clk;

  prog_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  prog_sequencer #(
    .PC_W      (PC_W),
    .NUM_PROGS (NUM_PROGS),
    .PROG0_ADDR(0),
    .PROG1_ADDR(256),
    .PROG2_ADDR(512),
    .PROG3_ADDR(768),
    .CNT_W     (CNT_W),
    .WDOG_LIMIT(WDOG_LIMIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic int entryOf(input int idx);
    case (idx)
      1: return 256;
      2: return 512;
      default: return 0;
    endcase
  endfunction

  function automatic int expCount();
    return (runLen > MAX_COUNT) ? MAX_COUNT : runLen;
  endfunction

  task automatic modelReset();
    phase    = M_IDLE;
    runLen   = 0;
    advances = 0;
    tmo      = 1'b0;
  endtask

  // One clock edge of the reference behaviour for the given inputs.
  task automatic modelStep(input bit s, input bit h);
    case (phase)
      M_IDLE:  if (s) phase = M_ARMED;
      M_ARMED: if (!s) begin phase = M_RUN; runLen = 0; end
      M_RUN: begin
        if (s) begin
          phase = M_ARMED;
          tmo   = 1'b0;
        end else if (h) begin
          phase = M_DONE;
        end else if (WDOG_ON && expCount() == WDOG_LIMIT) begin
          phase = M_DONE;
          tmo   = 1'b1;
        end else begin
          runLen++;
        end
      end
      M_DONE: if (s) begin phase = M_ARMED; advances++; tmo = 1'b0; end
      default: phase = M_IDLE;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, actual, expected);
    else
      passCount++;
  endtask

  task automatic checkAll();
    checkOutput("pc_hold", bus.pc_hold, phase != M_RUN);
    checkOutput("pc_load", bus.pc_load, phase == M_ARMED);
    checkOutput("running", bus.running, phase == M_RUN);
    checkOutput("done", bus.done, phase == M_DONE);
    checkOutput("prog_idx", bus.prog_idx, advances % NUM_PROGS);
    checkOutput("pc_load_addr", bus.pc_load_addr, entryOf(advances % NUM_PROGS));
    checkOutput("cycle_count", bus.cycle_count, expCount());
    checkOutput("timeout", bus.timeout, tmo);
  endtask

  // Called on a falling edge: drive inputs, take one rising edge, compare
  // on the next falling edge.
  task automatic applyStimulus(input bit s, input bit h);
    bus.start = s;
    bus.halt  = h;
    @(posedge clk);
    modelStep(s, h);
    @(negedge clk);
    checkAll();
  endtask

  // Reset asserted between edges must act before the next rising edge.
  task automatic pulseReset();
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("rst_async_idx", bus.prog_idx, 0);
    checkOutput("rst_async_hold", bus.pc_hold, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkAll();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("idle_hold", bus.pc_hold, 1);

    // First program: armed for three cycles, halt in the tenth run cycle.
    repeat (3) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("arm_load_addr", bus.pc_load_addr, 0);
    end
    applyStimulus(1'b0, 1'b0);
    repeat (9) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("first_count", bus.cycle_count, 9);
    checkOutput("first_done", bus.done, 1);

    // Next two programs select the following entry addresses.
    for (int p = 1; p <= 2; p++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("next_idx", bus.prog_idx, p);
      checkOutput("next_addr", bus.pc_load_addr, p * 256);
      applyStimulus(1'b0, 1'b0);
      repeat (p + 2) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("next_done", bus.done, 1);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("wrap_idx", bus.prog_idx, 0);
    checkOutput("wrap_addr", bus.pc_load_addr, 0);

    // Start and halt together while running: start wins.
    applyStimulus(1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_load", bus.pc_load, 1);
    checkOutput("abort_idx", bus.prog_idx, 0);

    // Advance to program 1, then reset while it runs.
    applyStimulus(1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0);
    pulseReset();

    // Long run without halt.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (30) applyStimulus(1'b0, 1'b0);
`ifdef PROG_WATCHDOG_EN
    checkOutput("wdog_done", bus.done, 1);
    checkOutput("wdog_timeout", bus.timeout, 1);
    checkOutput("wdog_count", bus.cycle_count, WDOG_LIMIT);
`else
    checkOutput("nowdog_running", bus.running, 1);
    checkOutput("nowdog_timeout", bus.timeout, 0);
    checkOutput("nowdog_count", bus.cycle_count, 30);
`endif
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart_timeout", bus.timeout, 0);

    // Randomized program series.
    for (int n = 0; n < 60; n++) begin
      int  rl;
      bit  noHalt;
      int  endChoice;
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 3)) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
      applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      rl     = int'($urandom_range(0, 70));
      noHalt = 1'($urandom_range(0, 1));
      repeat (rl) applyStimulus(1'b0, !noHalt && ($urandom_range(0, 15) == 0));
      endChoice = int'($urandom_range(0, 2));
      case (endChoice)
        0: applyStimulus(1'b0, 1'b1);
        1: applyStimulus(1'b1, 1'b0);
        default: applyStimulus(1'b1, 1'b1);
      endcase
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
